// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the multiplexed seven-segment
// display driver.
//   state_t      scan FSM states (IDLE / BLANK / DRIVE)
//   NUM_DIG      number of digits scanned per frame
//   SEG_*        active-low segment patterns {dp,g,f,e,d,c,b,a}, dp off
//   DP_MASK      digits whose decimal point is lit (hh.mm.ss separators)
//   nibble_sel   picks BCD nibble k out of the packed 24-bit time word
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  localparam int NUM_DIG = 6;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

  localparam logic [5:0] DP_MASK = 6'b010100;

  // Nibble k of the time word; digit 0 is seconds ones, digit 5 hours tens.
  function automatic logic [3:0] nibble_sel(input logic [23:0] word,
                                            input logic [2:0]  idx);
    logic [3:0] nib;
    case (idx)
      3'd0:    nib = word[3:0];
      3'd1:    nib = word[7:4];
      3'd2:    nib = word[11:8];
      3'd3:    nib = word[15:12];
      3'd4:    nib = word[19:16];
      3'd5:    nib = word[23:20];
      default: nib = 4'd0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low seven-segment pattern.
// The decimal point is always off here; it is overlaid by the caller.
// Non-BCD nibbles (A..F) show a dash.
//   bcd    in  4  BCD digit
//   seg_n  out 8  active-low segments {dp,g,f,e,d,c,b,a}
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg_n
);

  // Pattern lookup.
  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: six-digit multiplexed seven-segment driver for a common-anode
// display. Each digit slot is DEAD_CYC dark cycles followed by
// SCAN_CYC-DEAD_CYC driven cycles. The time word is captured once per frame
// so a frame never mixes digits from before and after a counter rollover.
// Optional feature macro: SEG_LZB_EN (blank the hours-tens digit when zero).
//   clk         in  1   system clock
//   rst_n       in  1   synchronous active-low reset
//   en          in  1   scan enable; low forces dark and idle
//   time_in     in  24  packed BCD {hh, mm, ss}
//   seg_n       out 8   active-low segments {dp,g,f,e,d,c,b,a}
//   dig_n       out 6   active-low digit strobes, bit k = digit k
//   frame_done  out 1   one-cycle pulse at start of the next frame
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_CYC = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] time_in,
  output logic [7:0]  seg_n,
  output logic [5:0]  dig_n,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_CYC);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(SCAN_CYC - DEAD_CYC - 1);
  localparam logic [2:0]       LAST_DIG   = 3'(NUM_DIG - 1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       digit_r, digit_s;
  logic [23:0]      snap_r, snap_s;
  logic [7:0]       seg_n_r, seg_s;
  logic [5:0]       dig_n_r, dig_s;
  logic             frame_done_r, frame_done_s;
  logic [3:0]       nib_s;
  logic [7:0]       dec_s;
  logic             lzb_s;

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    digit_s      = digit_r;
    snap_s       = snap_r;
    frame_done_s = 1'b0;
    if (!en) begin
      state_s = IDLE;
      cnt_s   = '0;
      digit_s = 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          snap_s  = time_in;
          digit_s = 3'd0;
          cnt_s   = '0;
          state_s = BLANK;
        end
        BLANK: begin
          if (cnt_r == DEAD_LAST) begin
            cnt_s   = '0;
            state_s = DRIVE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (cnt_r == DRIVE_LAST) begin
            cnt_s   = '0;
            state_s = BLANK;
            if (digit_r == LAST_DIG) begin
              // Frame boundary: the only point where a new time word is taken.
              digit_s      = 3'd0;
              snap_s       = time_in;
              frame_done_s = 1'b1;
            end else begin
              digit_s = digit_r + 3'd1;
            end
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          digit_s = 3'd0;
        end
      endcase
    end
  end

  // The snapshot only changes on entry to BLANK, so in DRIVE snap_r is current.
  assign nib_s = nibble_sel(snap_r, digit_s);

  bcd_to_seg7 u_dec (
    .bcd   (nib_s),
    .seg_n (dec_s)
  );

`ifdef SEG_LZB_EN
  assign lzb_s = (digit_s == LAST_DIG) && (nib_s == 4'd0);
`else
  assign lzb_s = 1'b0;
`endif

  // Output pattern for the upcoming cycle, registered below.
  always_comb begin
    seg_s = SEG_OFF;
    dig_s = 6'h3F;
    if (state_s == DRIVE) begin
      dig_s = ~(6'b000001 << digit_s);
      if (lzb_s) begin
        seg_s = SEG_OFF;
      end else if (DP_MASK[digit_s]) begin
        seg_s = {1'b0, dec_s[6:0]};
      end else begin
        seg_s = dec_s;
      end
    end else begin
      seg_s = SEG_OFF;
      dig_s = 6'h3F;
    end
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      digit_r      <= 3'd0;
      snap_r       <= 24'd0;
      seg_n_r      <= SEG_OFF;
      dig_n_r      <= 6'h3F;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      digit_r      <= digit_s;
      snap_r       <= snap_s;
      seg_n_r      <= seg_s;
      dig_n_r      <= dig_s;
      frame_done_r <= frame_done_s;
    end
  end

  assign seg_n      = seg_n_r;
  assign dig_n      = dig_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed six-digit seven-segment driver for the digital clock. It takes the packed BCD time word produced by the clock core (hh:mm:ss, two BCD digits per 8-bit field) and time-multiplexes it onto a common-anode display. Active-low segment and digit strobes are used, with a dead-time gap between digits to suppress ghosting. The time word is snapshotted once per frame so all six digits in a frame are coherent even when the counters roll over mid-scan.

## Interface
- SCAN_CYC, 50000: clock cycles per digit slot (1 ms at 50 MHz); legal range 2..2^20-1.
- DEAD_CYC, 500: blank cycles at the start of each slot; legal range 1..SCAN_CYC-1.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- en  in  1  scan enable; low forces display dark and idle.
- time_in  in  24  {hh[23:16], mm[15:8], ss[7:0]}, each field two BCD nibbles.
- seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- dig_n  out  6  active-low digit enables; bit k = digit k.
- frame_done  out  1  one-cycle pulse at end of each complete 6-digit frame.

## Operation
- Digit map: k=0 time_in[3:0] (sec ones) … k=5 time_in[23:20] (hour tens); nibble k = snapshot[4k+3:4k].
- FSM states: IDLE, BLANK, DRIVE. Digit index 0..5, slot counter sized for SCAN_CYC.
- IDLE: seg_n=8'hFF, dig_n=6'h3F. On en=1: snapshot<=time_in, digit<=0, cnt<=0, go to BLANK.
- BLANK: outputs dark; after DEAD_CYC cycles go to DRIVE, cnt<=0.
- DRIVE: dig_n[digit]=0, others 1; seg_n=decode(nibble). After SCAN_CYC-DEAD_CYC cycles, the FSM does one of the following:
  - digit<5: digit+1, go to BLANK.
  - digit==5: frame_done=1 for one cycle, digit<=0, snapshot<=time_in, go to BLANK.
- Decode (seg_n, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Nibble >9 shows '-' (BF).
- dp lit (bit7=0) on digits 2 and 4 (hh.mm.ss separators).
- en low in any state: next edge goes to IDLE, outputs dark, frame_done=0; a partial frame is abandoned. Re-enable restarts at digit 0 with a fresh snapshot.
- time_in changes mid-frame have no effect until the next frame boundary.

## Timing
- All outputs registered; reset values are seg_n=FF, dig_n=3F, frame_done=0, state IDLE.
- Edge E samples en=1 in IDLE. Outputs stay dark for DEAD_CYC cycles after E. dig_n[0] asserts at E+DEAD_CYC and holds SCAN_CYC-DEAD_CYC cycles.
- Slot period is exactly SCAN_CYC cycles; frame period is exactly 6*SCAN_CYC cycles; frame_done period is 6*SCAN_CYC.
- frame_done is high in the first BLANK cycle of the next frame, coincident with the new snapshot.
- There is never more than one dig_n bit low. dig_n and seg_n change only at slot/blank boundaries.
- Reset wins over en on the same edge.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking. When hour tens nibble == 0, digit 5 DRIVE outputs seg_n=FF. dig_n[5] still asserts and timing is unchanged.
- SEG_LZB_EN undefined: hour tens 0 displays '0' (C0).

## Structure
- Package seg_pkg holds:
  - the state enum (IDLE/BLANK/DRIVE);
  - NUM_DIG=6;
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_OFF;
  - DP digit mask 6'b010100.
- Sub-module bcd_to_seg7: combinational nibble-to-pattern decoder (no dp), instantiated once. The dp and LZB overrides are applied in seg_scan.

## Test plan
All scenarios use SCAN_CYC=10, DEAD_CYC=2.
- Reset: hold rst_n=0 with en=1 → seg_n=FF, dig_n=3F, frame_done=0. Release with time_in=24'h123456 → digit 0 drives seg_n=92 (5 is sec ones? no, sec ones is 6 → 82) on cycles 2..9 with dig_n=3E. Full sequence 82,92,99(dp→19),B0,A4(dp→24),F9.
- Frame timing: run 3 frames → frame_done pulses spaced 60 cycles. Exactly one dig_n bit low in DRIVE, none in BLANK.
- Snapshot coherence: change time_in 12:59:59→13:00:00 during digit 3 → current frame completes 12:59:59. The next frame shows 13:00:00.
- Invalid BCD: time_in=24'hFA0000 → digits 4,5 show '-' (digit 4 with dp: 3F, digit 5: BF).
- Mid-frame disable: drop en during digit 2 DRIVE → next cycle dark, no frame_done. Re-raise → restart at digit 0 after 2 dark cycles.
- LZB: time_in=24'h090000 → digit 5 seg_n=FF with SEG_LZB_EN, C0 without; dig_n[5] asserted in both.
